// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage.
// Contents: default bus widths, the zero instruction word, the fetch-state
// encoding (IDLE/FETCH/WAIT/DROP/EXC) and the PC increment constant.
// No ports; imported by if_fetch_unit and fetch_skid_buf.

package if_fetch_unit_pkg;

  localparam int DEF_XLEN = 32;
  localparam int INST_W   = 32;

  typedef logic [DEF_XLEN-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]   inst_bus_t;

  localparam inst_bus_t ZERO_WORD = '0;

  // Fetch FSM encoding, kept as plain constants so older blocks can share it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_EXC   = 3'd4;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry output register plus one pending register between instruction
// memory and the IF/ID pipeline register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             drop both entries (redirect)
//   stall_i             downstream does not consume the output this edge
//   load_i              a fetched instruction arrives (load_pc_i/load_inst_i)
//   exc_set_i, exc_pc_i with flush_i: present a misaligned-fetch marker
//   out_free_o          output can accept a new instruction at this edge
//   out_valid_o, out_pc_o, out_inst_o, out_exc_o   registered outputs

module fetch_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [XLEN-1:0]   load_pc_i,
  input  logic [INST_W-1:0] load_inst_i,
  input  logic              exc_set_i,
  input  logic [XLEN-1:0]   exc_pc_i,
  output logic              out_free_o,
  output logic              out_valid_o,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              out_exc_o
);

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic              out_exc_q, out_exc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic [INST_W-1:0] pend_inst_q, pend_inst_d;
  logic              consume;

  assign consume    = out_valid_q && !stall_i;
  assign out_free_o = !out_valid_q || !stall_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_exc_d    = out_exc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_inst_d  = pend_inst_q;

    if (flush_i) begin
      // Flush keeps out_pc so the last PC stays observable, unless an
      // exception marker takes the output slot.
      out_valid_d  = exc_set_i;
      out_inst_d   = ZERO_WORD;
      out_exc_d    = exc_set_i;
      pend_valid_d = 1'b0;
      if (exc_set_i) out_pc_d = exc_pc_i;
    end else if (consume) begin
      out_exc_d = 1'b0;
      if (pend_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = pend_pc_q;
        out_inst_d   = pend_inst_q;
        pend_valid_d = load_i;
        pend_pc_d    = load_pc_i;
        pend_inst_d  = load_inst_i;
      end else if (load_i) begin
        out_valid_d = 1'b1;
        out_pc_d    = load_pc_i;
        out_inst_d  = load_inst_i;
      end else begin
        // Bubble: PC holds, instruction reads as zero.
        out_valid_d = 1'b0;
        out_inst_d  = ZERO_WORD;
      end
    end else if (!out_valid_q) begin
      if (load_i) begin
        out_valid_d = 1'b1;
        out_pc_d    = load_pc_i;
        out_inst_d  = load_inst_i;
        out_exc_d   = 1'b0;
      end
    end else if (load_i) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = load_pc_i;
      pend_inst_d  = load_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= ZERO_WORD;
      out_exc_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_inst_q  <= ZERO_WORD;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_exc_q    <= out_exc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_inst_q  <= pend_inst_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pc_o    = out_pc_q;
  assign out_inst_o  = out_inst_q;
  assign out_exc_o   = out_exc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and presents them to the IF/ID register. Honours stall and
// redirect; data returned for a redirected-away request is discarded.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_i                  IF/ID holds, output not consumed this edge
//   redirect_i, redirect_pc_i  flush and restart fetch at the target
//   mem_req_o, mem_addr_o    fetch request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i   one-cycle response with instruction word
//   if_pc_o, if_inst_o, if_valid_o, if_exc_o   registered IF outputs
// Configuration: IF_MISALIGN_EXC_EN enables the misaligned-target exception
// (EXC state); without it target bits [1:0] are forced to zero.

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int               XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              if_exc_o
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic            ack;
  logic            load;
  logic            out_free;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_misaligned;
  logic            pc_misaligned;
  logic [XLEN-1:0] pc_plus4;

`ifdef IF_MISALIGN_EXC_EN
  assign tgt_pc         = redirect_pc_i;
  assign tgt_misaligned = (redirect_pc_i[1:0] != 2'b00);
  // pc only holds a misaligned value after a misaligned redirect, so it
  // tells DROP whether to fetch or to park in EXC once the ack arrives.
  assign pc_misaligned  = (pc_q[1:0] != 2'b00);
`else
  assign tgt_pc         = redirect_pc_i & ~XLEN'(3);
  assign tgt_misaligned = 1'b0;
  assign pc_misaligned  = 1'b0;
`endif

  assign ack      = mem_ack_i && mem_req_q;
  assign load     = ack && (state_q == ST_FETCH) && !redirect_i;
  assign pc_plus4 = pc_q + XLEN'(PC_INC);

  // Next-state logic. Redirect beats stall and ack; a request still in
  // flight without its ack is tracked in DROP so the returning word dies.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    if (redirect_i) begin
      pc_d = tgt_pc;
      if ((state_q == ST_FETCH || state_q == ST_DROP) && !ack) begin
        state_d   = ST_DROP;
        mem_req_d = 1'b1;
      end else if (tgt_misaligned) begin
        state_d   = ST_EXC;
        mem_req_d = 1'b0;
      end else begin
        // A DROP whose ack lands on this edge has nothing left to wait for.
        state_d    = ST_FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = tgt_pc;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        ST_FETCH: begin
          if (ack) begin
            pc_d = pc_plus4;
            if (!out_free) begin
              state_d   = ST_WAIT;
              mem_req_d = 1'b0;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_plus4;
            end
          end
        end
        ST_WAIT: begin
          if (if_valid_o && !stall_i) begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        ST_DROP: begin
          if (ack) begin
            if (pc_misaligned) begin
              state_d   = ST_EXC;
              mem_req_d = 1'b0;
            end else begin
              state_d    = ST_FETCH;
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
            end
          end
        end
        default: begin
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_i),
    .stall_i    (stall_i),
    .load_i     (load),
    .load_pc_i  (mem_addr_q),
    .load_inst_i(mem_rdata_i),
    .exc_set_i  (tgt_misaligned),
    .exc_pc_i   (tgt_pc),
    .out_free_o (out_free),
    .out_valid_o(if_valid_o),
    .out_pc_o   (if_pc_o),
    .out_inst_o (if_inst_o),
    .out_exc_o  (if_exc_o)
  );

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
// Directed testbench for if_fetch_unit: reset values, back-to-back
// streaming, stall/WAIT, redirect with outstanding request, redirect with
// coincident ack and stall, double redirect in DROP, PC wrap, and the
// misaligned-target behaviour (IF_MISALIGN_EXC_EN on or off).

module tb_if_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        if_exc_o;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_valid_o   (if_valid_o),
    .if_exc_o     (if_exc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model answering each visible request at the next edge.
  task automatic drive_mem();
    mem_ack_i   = mem_req_o;
    mem_rdata_i = mem_addr_o ^ PAT;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) drive_mem();
  endtask

  task automatic test_reset();
    rst = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0; auto_ack = 0;
    tick(); tick();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", mem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h expected 0", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst: got %h expected 0", if_inst_o); end
    checks++; if (if_exc_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_exc: got %b expected 0", if_exc_o); end
    rst = 0;
    tick();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL first_addr: got %h expected 0", mem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL first_valid: got %b expected 0", if_valid_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    auto_ack = 1;
    drive_mem();
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, if_valid_o); end
      checks++; if (if_pc_o !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, if_pc_o, exp_pc); end
      checks++; if (if_inst_o !== (exp_pc ^ PAT)) begin errors++; $display("[TB] FAIL stream_inst[%0d]: got %h expected %h", i, if_inst_o, exp_pc ^ PAT); end
      checks++; if (mem_addr_o !== exp_pc + 32'd4) begin errors++; $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", i, mem_addr_o, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_stall();
    stall_i = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (if_pc_o !== 32'h14) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 00000014", i, if_pc_o); end
      checks++; if (if_inst_o !== (32'h14 ^ PAT)) begin errors++; $display("[TB] FAIL stall_inst[%0d]: got %h expected %h", i, if_inst_o, 32'h14 ^ PAT); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, mem_req_o); end
    end
    stall_i = 0;
    tick();
    checks++; if (if_pc_o !== 32'h18) begin errors++; $display("[TB] FAIL release_pc0: got %h expected 00000018", if_pc_o); end
    checks++; if (if_inst_o !== (32'h18 ^ PAT)) begin errors++; $display("[TB] FAIL release_inst0: got %h expected %h", if_inst_o, 32'h18 ^ PAT); end
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h1C) begin errors++; $display("[TB] FAIL release_addr: got %h expected 0000001c", mem_addr_o); end
    tick();
    checks++; if (if_pc_o !== 32'h1C) begin errors++; $display("[TB] FAIL release_pc1: got %h expected 0000001c", if_pc_o); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL release_valid1: got %b expected 1", if_valid_o); end
    checks++; if (mem_addr_o !== 32'h20) begin errors++; $display("[TB] FAIL release_addr1: got %h expected 00000020", mem_addr_o); end
  endtask

  task automatic test_redirect_outstanding();
    auto_ack = 0; mem_ack_i = 0; rst = 1;
    tick();
    rst = 0;
    tick();
    auto_ack = 1;
    drive_mem();
    tick(); tick(); tick();
    auto_ack = 0;
    tick();
    mem_ack_i = 0;
    checks++; if (mem_addr_o !== 32'h10) begin errors++; $display("[TB] FAIL pre_redir_addr: got %h expected 00000010", mem_addr_o); end
    checks++; if (if_pc_o !== 32'hC) begin errors++; $display("[TB] FAIL pre_redir_pc: got %h expected 0000000c", if_pc_o); end
    redirect_i = 1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("[TB] FAIL redir_inst: got %h expected 0", if_inst_o); end
    checks++; if (mem_addr_o !== 32'h10) begin errors++; $display("[TB] FAIL drop_addr: got %h expected 00000010", mem_addr_o); end
    tick(); tick();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL drop_req: got %b expected 1", mem_req_o); end
    mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_ack_i = 0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_discard_valid: got %b expected 0", if_valid_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL drop_next_addr: got %h expected 00000100", mem_addr_o); end
    mem_ack_i = 1; mem_rdata_i = 32'h100 ^ PAT;
    tick();
    mem_ack_i = 0;
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL target_valid: got %b expected 1", if_valid_o); end
    checks++; if (if_pc_o !== 32'h100) begin errors++; $display("[TB] FAIL target_pc: got %h expected 00000100", if_pc_o); end
    checks++; if (if_inst_o !== (32'h100 ^ PAT)) begin errors++; $display("[TB] FAIL target_inst: got %h expected %h", if_inst_o, 32'h100 ^ PAT); end
  endtask

  task automatic test_redirect_ack_stall();
    stall_i = 1; mem_ack_i = 1; mem_rdata_i = 32'h104 ^ PAT;
    redirect_i = 1; redirect_pc_i = 32'h40;
    tick();
    redirect_i = 0; mem_ack_i = 0; stall_i = 0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ras_valid: got %b expected 0", if_valid_o); end
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL ras_req: got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h40) begin errors++; $display("[TB] FAIL ras_addr: got %h expected 00000040", mem_addr_o); end
    mem_ack_i = 1; mem_rdata_i = 32'h40 ^ PAT;
    tick();
    mem_ack_i = 0;
    checks++; if (if_pc_o !== 32'h40) begin errors++; $display("[TB] FAIL ras_pc: got %h expected 00000040", if_pc_o); end
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ras_valid2: got %b expected 1", if_valid_o); end
  endtask

  task automatic test_double_redirect();
    redirect_i = 1; redirect_pc_i = 32'h200;
    tick();
    checks++; if (mem_addr_o !== 32'h44) begin errors++; $display("[TB] FAIL dbl_drop_addr: got %h expected 00000044", mem_addr_o); end
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 0;
    checks++; if (mem_addr_o !== 32'h44) begin errors++; $display("[TB] FAIL dbl_drop_addr2: got %h expected 00000044", mem_addr_o); end
    mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
    tick();
    mem_ack_i = 0;
    checks++; if (mem_addr_o !== 32'h300) begin errors++; $display("[TB] FAIL dbl_target: got %h expected 00000300", mem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL dbl_valid: got %b expected 0", if_valid_o); end
    mem_ack_i = 1; mem_rdata_i = 32'h300 ^ PAT;
    tick();
    mem_ack_i = 0;
    checks++; if (if_pc_o !== 32'h300) begin errors++; $display("[TB] FAIL dbl_pc: got %h expected 00000300", if_pc_o); end
  endtask

  task automatic test_wrap();
    mem_ack_i = 1; mem_rdata_i = 32'h304 ^ PAT;
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 0;
    checks++; if (mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", mem_addr_o); end
    auto_ack = 1;
    drive_mem();
    tick();
    checks++; if (if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", if_pc_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 00000000", mem_addr_o); end
    tick();
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc1: got %h expected 00000000", if_pc_o); end
    checks++; if (if_inst_o !== PAT) begin errors++; $display("[TB] FAIL wrap_inst1: got %h expected %h", if_inst_o, PAT); end
    auto_ack = 0; mem_ack_i = 0;
  endtask

  task automatic test_misaligned();
    stall_i = 1; mem_ack_i = 1; mem_rdata_i = 32'h0;
    redirect_i = 1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 0; mem_ack_i = 0;
`ifdef IF_MISALIGN_EXC_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_req[%0d]: got %b expected 0", i, mem_req_o); end
      checks++; if (if_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL exc_valid[%0d]: got %b expected 1", i, if_valid_o); end
      checks++; if (if_exc_o !== 1'b1) begin errors++; $display("[TB] FAIL exc_flag[%0d]: got %b expected 1", i, if_exc_o); end
      checks++; if (if_pc_o !== 32'h102) begin errors++; $display("[TB] FAIL exc_pc[%0d]: got %h expected 00000102", i, if_pc_o); end
      checks++; if (if_inst_o !== 32'h0) begin errors++; $display("[TB] FAIL exc_inst[%0d]: got %h expected 0", i, if_inst_o); end
      tick();
    end
    redirect_i = 1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 0;
    checks++; if (if_exc_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_clear: got %b expected 0", if_exc_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_clear_valid: got %b expected 0", if_valid_o); end
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL exc_exit_req: got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL exc_exit_addr: got %h expected 00000200", mem_addr_o); end
`else
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL align_req: got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL align_addr: got %h expected 00000100", mem_addr_o); end
    checks++; if (if_exc_o !== 1'b0) begin errors++; $display("[TB] FAIL align_exc: got %b expected 0", if_exc_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL align_valid: got %b expected 0", if_valid_o); end
`endif
    stall_i = 0;
  endtask

  initial begin
    $display("[TB] starting if_fetch_unit bench");
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_outstanding();
    test_redirect_ack_stall();
    test_double_redirect();
    test_wrap();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
